// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the front-end blocks.
// Fetch queue sizing and the architectural reset PC live here.
package cpu_pkg;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          FQ_DEPTH = 4;
   localparam int          INSTR_W  = 32;

endpackage

// File: rtl/fq_regfile.sv
// Fetch queue entry storage: one write port, one async read port.
// No reset; entry validity is tracked by the owner's count.
module fq_regfile
   import cpu_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int DW    = 2 * INSTR_W,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue with flush and PC-hold stall.
// Handshake outputs depend only on registered count (no bypass).
module fetch_queue
   import cpu_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int WIDTH = INSTR_W
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       enq_valid,
   input  logic [WIDTH-1:0]           enq_pc,
   input  logic [WIDTH-1:0]           enq_instr,
   output logic                       enq_ready,
   output logic                       stall_signal,
   output logic                       deq_valid,
   output logic [WIDTH-1:0]           deq_pc,
   output logic [WIDTH-1:0]           deq_instr,
   input  logic                       deq_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0]      rd_ptr;
   logic [PW-1:0]      wr_ptr;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] rd_data;
   logic               enq_fire;
   logic               deq_fire;

   assign enq_ready    = (cnt != FULL);
   assign stall_signal = ~enq_ready;
   assign deq_valid    = (cnt != '0);
   assign count        = cnt;

   assign enq_fire = enq_valid & enq_ready;
   assign deq_fire = deq_valid & deq_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (enq_fire)
            wr_ptr <= wr_ptr + PW'(1);
         if (deq_fire)
            rd_ptr <= rd_ptr + PW'(1);
         case ({enq_fire, deq_fire})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   fq_regfile #(
      .DEPTH (DEPTH),
      .DW    (2 * WIDTH),
      .AW    (PW)
   ) u_regfile (
      .clock (clock),
      .we    (enq_fire & ~flush),
      .waddr (wr_ptr),
      .wdata ({enq_pc, enq_instr}),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

   // Empty queue presents zeros rather than stale storage.
   assign {deq_pc, deq_instr} = deq_valid ? rd_data : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int WIDTH = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             flush = 1'b0;
   logic             enq_valid = 1'b0;
   logic [WIDTH-1:0] enq_pc = '0;
   logic [WIDTH-1:0] enq_instr = '0;
   logic             enq_ready;
   logic             stall_signal;
   logic             deq_valid;
   logic [WIDTH-1:0] deq_pc;
   logic [WIDTH-1:0] deq_instr;
   logic             deq_ready = 1'b0;
   logic [CW-1:0]    count;

   int checks   = 0;
   int failures = 0;

   logic [63:0] model_q [$];

   fetch_queue #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .enq_valid    (enq_valid),
      .enq_pc       (enq_pc),
      .enq_instr    (enq_instr),
      .enq_ready    (enq_ready),
      .stall_signal (stall_signal),
      .deq_valid    (deq_valid),
      .deq_pc       (deq_pc),
      .deq_instr    (deq_instr),
      .deq_ready    (deq_ready),
      .count        (count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      logic [63:0] head;
      n = model_q.size();
      head = (n != 0) ? model_q[0] : 64'd0;
      check({tag, ".count"}, 64'(count), 64'(n));
      check({tag, ".enq_ready"}, 64'(enq_ready), 64'(n != DEPTH));
      check({tag, ".stall"}, 64'(stall_signal), 64'(n == DEPTH));
      check({tag, ".deq_valid"}, 64'(deq_valid), 64'(n != 0));
      check({tag, ".deq_pc"}, 64'(deq_pc), 64'(head[63:32]));
      check({tag, ".deq_instr"}, 64'(deq_instr), 64'(head[31:0]));
   endtask

   // Advance one clock, apply the queue rules to the model, compare.
   task automatic step(input string tag);
      bit enf, def;
      @(posedge clock);
      if (reset || flush) begin
         model_q.delete();
      end else begin
         enf = enq_valid && (model_q.size() != DEPTH);
         def = deq_ready && (model_q.size() != 0);
         if (def) void'(model_q.pop_front());
         if (enf) model_q.push_back({enq_pc, enq_instr});
      end
      #1;
      check_all(tag);
   endtask

   task automatic drive(input bit fl, input bit ev, input logic [31:0] pc,
                        input bit dr);
      flush     = fl;
      enq_valid = ev;
      enq_pc    = pc;
      enq_instr = ~pc ^ 32'h1357_9bdf;
      deq_ready = dr;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      logic [31:0] pc;
      #2;
      check_all("reset_hold");
      @(negedge clock);
      check_all("reset_hold2");
      reset = 1'b0;
      step("post_reset");

      // Three enqueues with decode stalled.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 32'h0040_0000 + 32'(4 * i), 1'b0);
         step("enq3");
      end
      check("enq3.count", 64'(count), 64'd3);
      check("enq3.head", 64'(deq_pc), 64'h0040_0000);

      // Fill, then push against full with and without dequeue.
      drive(1'b0, 1'b1, 32'h0040_000c, 1'b0);
      step("fill");
      check("fill.stall", 64'(stall_signal), 64'd1);
      drive(1'b0, 1'b1, 32'h0040_0020, 1'b0);
      step("full_enq");
      drive(1'b0, 1'b1, 32'h0040_0024, 1'b1);
      step("full_enq_deq");
      check("full_deq.count", 64'(count), 64'd3);
      check("full_deq.ready", 64'(enq_ready), 64'd1);

      // Steady stream at occupancy one.
      drive(1'b1, 1'b0, 32'h0, 1'b0);
      step("flush_a");
      drive(1'b0, 1'b1, 32'h0040_0100, 1'b0);
      step("stream_seed");
      pc = 32'h0040_0104;
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, pc, 1'b1);
         step("stream");
         check("stream.pc", 64'(deq_pc), 64'(pc));
         pc += 32'd4;
      end

      // Flush with an enqueue in the same cycle.
      idle();
      drive(1'b0, 1'b1, 32'h0040_0200, 1'b1);
      step("pre_flush");
      drive(1'b0, 1'b1, 32'h0040_0204, 1'b0);
      step("pre_flush");
      drive(1'b0, 1'b1, 32'h0040_0208, 1'b0);
      step("pre_flush");
      check("pre_flush.count", 64'(count), 64'd3);
      drive(1'b1, 1'b1, 32'h0040_0040, 1'b1);
      step("flush_enq");
      check("flush.count", 64'(count), 64'd0);
      check("flush.valid", 64'(deq_valid), 64'd0);

      // No bypass from enqueue to dequeue.
      drive(1'b0, 1'b1, 32'h0040_0010, 1'b1);
      #1;
      check("nobypass.valid_n", 64'(deq_valid), 64'd0);
      step("nobypass");
      check("nobypass.valid_n1", 64'(deq_valid), 64'd1);
      check("nobypass.pc_n1", 64'(deq_pc), 64'h0040_0010);

      // Asynchronous reset mid-cycle with two entries.
      drive(1'b0, 1'b1, 32'h0040_0014, 1'b0);
      step("pre_reset");
      idle();
      #2;
      reset = 1'b1;
      #1;
      check("async_rst.count", 64'(count), 64'd0);
      check("async_rst.valid", 64'(deq_valid), 64'd0);
      check("async_rst.ready", 64'(enq_ready), 64'd1);
      model_q.delete();
      #1;
      reset = 1'b0;
      step("post_async_rst");

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
               $urandom, $urandom_range(0, 2) != 0);
         step("rand");
      end

      idle();
      step("drain_idle");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
